// File: rtl/lfsr_pkg.sv
// Shared limits and helpers for the Galois LFSR / PRBS generator.
package lfsr_pkg;

    localparam int unsigned LfsrMinWidth = 2;
    localparam int unsigned LfsrMaxWidth = 32;

    typedef logic [LfsrMaxWidth-1:0] lfsr_word_t;

    // Right-shift Galois tap masks that give maximal-length sequences.
    function automatic lfsr_word_t lfsr_default_taps(input int unsigned width);
        lfsr_word_t t;
        case (width)
            2:       t = 32'h0000_0003;
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_B400;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

    function automatic lfsr_word_t lfsr_step(input lfsr_word_t state, input lfsr_word_t taps);
        return (state >> 1) ^ (state[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/lfsr_step_comb.sv
// One combinational right-shift Galois step; out_bit is the bit shifted out.
module lfsr_step_comb
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] next_state,
    output logic             out_bit
);

    assign next_state = WIDTH'(lfsr_step(lfsr_word_t'(state), lfsr_word_t'(taps)));
    assign out_bit    = state[0];

endmodule

// File: rtl/lfsr_galois_gen.sv
// Galois LFSR / PRBS generator: STEPS shifts per enabled cycle, runtime taps and seed,
// all-zero lock-up recovery and sequence period measurement.
module lfsr_galois_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      STEPS    = 1,
    parameter logic [WIDTH-1:0] DEF_SEED = WIDTH'(1),
    parameter logic [WIDTH-1:0] DEF_TAPS = WIDTH'(lfsr_default_taps(WIDTH))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] q,
    output logic [STEPS-1:0] bits_out,
    output logic             valid,
    output logic             wrap,
    output logic             lockup,
    output logic [WIDTH-1:0] period
);

    if (WIDTH < LfsrMinWidth || WIDTH > LfsrMaxWidth || STEPS < 1 || STEPS > WIDTH) begin : g_bad_params
        $error("lfsr_galois_gen: WIDTH or STEPS out of range");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] taps_q, taps_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [STEPS-1:0] bits_q, bits_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;

    logic [STEPS-1:0] step_bits;
    logic [STEPS-1:0] wrap_hit;
    logic [WIDTH-1:0] final_s;
    logic             dead;
    logic             hit_found;
    logic [WIDTH-1:0] hit_idx;
    logic [WIDTH:0]   sat_sum;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        logic [WIDTH-1:0] cur_s;
        logic [WIDTH-1:0] next_s;
        if (g == 0) begin : g_head
            assign cur_s = state_q;
        end else begin : g_link
            assign cur_s = g_step[g-1].next_s;
        end
        lfsr_step_comb #(
            .WIDTH(WIDTH)
        ) u_step (
            .state     (cur_s),
            .taps      (taps_q),
            .next_state(next_s),
            .out_bit   (step_bits[g])
        );
        assign wrap_hit[g] = (next_s == start_q);
    end

    assign final_s = g_step[STEPS-1].next_s;
    // A zero state is absorbing, so the chain ends at zero iff any stage hit zero.
    assign dead    = (final_s == '0);

    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int unsigned k = 0; k < STEPS; k++) begin
            if (wrap_hit[k] && !hit_found) begin
                hit_found = 1'b1;
                hit_idx   = WIDTH'(k + 1);
            end
        end
    end

    assign sat_sum = {1'b0, step_cnt_q} + (WIDTH+1)'(STEPS);

    always_comb begin
        state_d    = state_q;
        taps_d     = taps_q;
        start_d    = start_q;
        step_cnt_d = step_cnt_q;
        period_d   = period_q;
        bits_d     = bits_q;
        valid_d    = 1'b0;
        wrap_d     = 1'b0;
        lockup_d   = 1'b0;
        if (load) begin
            taps_d     = taps;
            state_d    = (seed == '0) ? DEF_SEED : seed;
            start_d    = state_d;
            lockup_d   = (seed == '0);
            step_cnt_d = '0;
        end else if (en) begin
            valid_d = 1'b1;
            bits_d  = step_bits;
            if (dead) begin
                state_d    = DEF_SEED;
                start_d    = DEF_SEED;
                lockup_d   = 1'b1;
                step_cnt_d = '0;
            end else begin
                state_d = final_s;
                if (hit_found) begin
                    wrap_d     = 1'b1;
                    period_d   = step_cnt_q + hit_idx;
                    step_cnt_d = WIDTH'(STEPS) - hit_idx;
                end else begin
                    step_cnt_d = sat_sum[WIDTH] ? '1 : sat_sum[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DEF_SEED;
            taps_q     <= DEF_TAPS;
            start_q    <= DEF_SEED;
            step_cnt_q <= '0;
            period_q   <= '0;
            bits_q     <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            lockup_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            taps_q     <= taps_d;
            start_q    <= start_d;
            step_cnt_q <= step_cnt_d;
            period_q   <= period_d;
            bits_q     <= bits_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
            lockup_q   <= lockup_d;
        end
    end

    assign q        = state_q;
    assign bits_out = bits_q;
    assign valid    = valid_q;
    assign wrap     = wrap_q;
    assign lockup   = lockup_q;
    assign period   = period_q;

endmodule

// File: tb/tb_lfsr_galois_gen.sv
// Directed bench for lfsr_galois_gen: 5-bit single/dual-step instances plus the default 16-bit one.
module tb_lfsr_galois_gen;

    logic       clk;
    logic       reset;
    logic       en5, load5;
    logic [4:0] seed5, taps5;
    logic       en16, load16;
    logic [15:0] seed16, taps16;

    logic [4:0]  q1, period1;
    logic [0:0]  bits1;
    logic        valid1, wrap1, lockup1;
    logic [4:0]  q2, period2;
    logic [1:0]  bits2;
    logic        valid2, wrap2, lockup2;
    logic [15:0] q16, period16;
    logic [0:0]  bits16;
    logic        valid16, wrap16, lockup16;

    int checks   = 0;
    int failures = 0;

    lfsr_galois_gen #(
        .WIDTH(5), .STEPS(1), .DEF_SEED(5'h01), .DEF_TAPS(5'h14)
    ) u_w5s1 (
        .clk(clk), .reset(reset), .en(en5), .load(load5), .seed(seed5), .taps(taps5),
        .q(q1), .bits_out(bits1), .valid(valid1), .wrap(wrap1), .lockup(lockup1),
        .period(period1)
    );

    lfsr_galois_gen #(
        .WIDTH(5), .STEPS(2), .DEF_SEED(5'h01), .DEF_TAPS(5'h14)
    ) u_w5s2 (
        .clk(clk), .reset(reset), .en(en5), .load(load5), .seed(seed5), .taps(taps5),
        .q(q2), .bits_out(bits2), .valid(valid2), .wrap(wrap2), .lockup(lockup2),
        .period(period2)
    );

    lfsr_galois_gen u_w16 (
        .clk(clk), .reset(reset), .en(en16), .load(load16), .seed(seed16), .taps(taps16),
        .q(q16), .bits_out(bits16), .valid(valid16), .wrap(wrap16), .lockup(lockup16),
        .period(period16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] exp1 [5];
        int first_wrap;
        int lock_cnt;
        exp1 = '{5'h14, 5'h0A, 5'h05, 5'h16, 5'h0B};

        reset = 1'b1; en5 = 1'b0; load5 = 1'b0; seed5 = '0; taps5 = '0;
        en16 = 1'b0; load16 = 1'b0; seed16 = '0; taps16 = '0;
        tick; tick;
        check("rst_q1", 32'(q1), 32'h01);
        check("rst_q2", 32'(q2), 32'h01);
        check("rst_q16", 32'(q16), 32'h0001);
        check("rst_valid1", 32'(valid1), 32'h0);
        check("rst_wrap1", 32'(wrap1), 32'h0);
        check("rst_lockup1", 32'(lockup1), 32'h0);
        check("rst_period1", 32'(period1), 32'h0);
        check("rst_bits2", 32'(bits2), 32'h0);
        check("rst_period16", 32'(period16), 32'h0);
        reset = 1'b0;

        // Load seed 1 / taps 0x14, then free-run one full period.
        seed5 = 5'h01; taps5 = 5'h14; load5 = 1'b1;
        tick;
        load5 = 1'b0;
        check("load_q1", 32'(q1), 32'h01);
        check("load_valid1", 32'(valid1), 32'h0);
        check("load_lockup1", 32'(lockup1), 32'h0);
        en5 = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            tick;
            if (c <= 5) check("t1_q", 32'(q1), 32'(exp1[c-1]));
            check("t1_wrap", 32'(wrap1), (c == 31) ? 32'h1 : 32'h0);
            check("t1_lockup", 32'(lockup1), 32'h0);
            check("t1_valid", 32'(valid1), 32'h1);
            if (c == 1) begin
                check("t2_q_c1", 32'(q2), 32'h0A);
                check("t2_bits_c1", 32'(bits2), 32'h1);
            end
            if (c == 2) begin
                check("t2_q_c2", 32'(q2), 32'h16);
                check("t2_bits_c2", 32'(bits2), 32'h2);
            end
            if (c <= 16) check("t2_wrap", 32'(wrap2), (c == 16) ? 32'h1 : 32'h0);
            if (c == 16) begin
                check("t2_period", 32'(period2), 32'd31);
                check("t2_q_wrap", 32'(q2), 32'h14);
            end
        end
        check("t1_period", 32'(period1), 32'd31);
        check("t1_q_wrap", 32'(q1), 32'h01);
        en5 = 1'b0;
        tick;
        check("idle_valid1", 32'(valid1), 32'h0);
        check("idle_wrap1", 32'(wrap1), 32'h0);
        check("idle_q1", 32'(q1), 32'h01);
        check("idle_period1", 32'(period1), 32'd31);

        // load and en together: load wins.
        seed5 = 5'h05; load5 = 1'b1; en5 = 1'b1;
        tick;
        load5 = 1'b0;
        check("t5_q1", 32'(q1), 32'h05);
        check("t5_valid1", 32'(valid1), 32'h0);
        check("t5_q2", 32'(q2), 32'h05);
        tick;
        en5 = 1'b0;
        check("t5_step_q1", 32'(q1), 32'h16);
        check("t5_step_valid1", 32'(valid1), 32'h1);
        check("t5_step_q2", 32'(q2), 32'h0B);
        check("t5_step_bits2", 32'(bits2), 32'h1);

        // Zero seed falls back to DEF_SEED, which also becomes the wrap reference.
        seed5 = 5'h00; taps5 = 5'h14; load5 = 1'b1;
        tick;
        load5 = 1'b0;
        check("t3_q1", 32'(q1), 32'h01);
        check("t3_lockup1", 32'(lockup1), 32'h1);
        check("t3_valid1", 32'(valid1), 32'h0);
        check("t3_lockup2", 32'(lockup2), 32'h1);
        tick;
        check("t3_lockup_clear", 32'(lockup1), 32'h0);
        en5 = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            tick;
            check("t3_wrap", 32'(wrap1), (c == 31) ? 32'h1 : 32'h0);
        end
        en5 = 1'b0;
        check("t3_period", 32'(period1), 32'd31);

        // Zero taps kill the sequence on the first step.
        seed5 = 5'h01; taps5 = 5'h00; load5 = 1'b1;
        tick;
        load5 = 1'b0; en5 = 1'b1;
        tick;
        en5 = 1'b0;
        check("t4_q1", 32'(q1), 32'h01);
        check("t4_lockup1", 32'(lockup1), 32'h1);
        check("t4_wrap1", 32'(wrap1), 32'h0);
        check("t4_valid1", 32'(valid1), 32'h1);
        check("t4_bits1", 32'(bits1), 32'h1);
        check("t4_q2", 32'(q2), 32'h01);
        check("t4_lockup2", 32'(lockup2), 32'h1);
        check("t4_bits2", 32'(bits2), 32'h1);
        tick;
        check("t4_lockup_clear", 32'(lockup1), 32'h0);

        // Reset mid-run overrides load and en.
        seed5 = 5'h01; taps5 = 5'h14; load5 = 1'b1;
        tick;
        load5 = 1'b0; en5 = 1'b1;
        tick; tick; tick;
        check("t6_pre_q1", 32'(q1), 32'h05);
        reset = 1'b1; load5 = 1'b1; seed5 = 5'h07;
        tick;
        reset = 1'b0; load5 = 1'b0;
        check("t6_q1", 32'(q1), 32'h01);
        check("t6_period1", 32'(period1), 32'h0);
        check("t6_valid1", 32'(valid1), 32'h0);
        check("t6_wrap1", 32'(wrap1), 32'h0);
        check("t6_lockup1", 32'(lockup1), 32'h0);
        check("t6_bits2", 32'(bits2), 32'h0);
        check("t6_q2", 32'(q2), 32'h01);
        tick;
        en5 = 1'b0;
        check("t6_deftaps_q1", 32'(q1), 32'h14);
        check("t6_deftaps_q2", 32'(q2), 32'h0A);

        // Default 16-bit instance runs a full maximal-length period.
        en16 = 1'b1;
        tick;
        check("w16_q_c1", 32'(q16), 32'hB400);
        check("w16_wrap_c1", 32'(wrap16), 32'h0);
        first_wrap = 0;
        lock_cnt = 0;
        for (int c = 2; c <= 65535; c++) begin
            tick;
            if (wrap16 && first_wrap == 0) first_wrap = c;
            if (lockup16) lock_cnt++;
        end
        en16 = 1'b0;
        check("w16_wrap_cycle", 32'(first_wrap), 32'd65535);
        check("w16_period", 32'(period16), 32'd65535);
        check("w16_q_wrap", 32'(q16), 32'h0001);
        check("w16_lockups", 32'(lock_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
